// File: rtl/dkm.sv
// Drink-vending machine controller. Each can costs 50 cents; nickels, dimes
// and quarters are accepted. A can is vended, with change returned from the
// nickel/dime inventory, when the deposit reaches 50 cents.
module dkm (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD_COINS,
    input  logic       LOAD_CANS,
    input  logic [7:0] NICKELS,
    input  logic [7:0] DIMES,
    input  logic [7:0] CANS,
    input  logic       NICKEL_IN,
    input  logic       DIME_IN,
    input  logic       QUARTER_IN,
    output logic       EMPTY,
    output logic       DISPENSE,
    output logic       NICKEL_OUT,
    output logic       DIME_OUT,
    output logic       TWO_DIME_OUT,
    output logic       USE_EXACT
);

    localparam logic [6:0] PRICE = 7'd50;

    logic [7:0] count_cans;
    logic [7:0] count_nickels;
    logic [7:0] count_dimes;
    logic [6:0] count_deposit;

    logic [6:0] coin_value;
    logic       coin_accept;
    logic [6:0] deposit_sum;
    logic       vend;
    logic [6:0] change;
    logic       need_nickel;
    logic       need_dime;
    logic       need_two_dimes;
    logic [8:0] cans_sum;
    logic [8:0] nickels_sum;
    logic [8:0] dimes_sum;
    logic       give_nickel;
    logic       give_dime;
    logic       give_two_dimes;
    logic [8:0] cans_raw;
    logic [8:0] nickels_raw;
    logic [8:0] dimes_raw;
    logic [7:0] cans_next;
    logic [7:0] nickels_next;
    logic [7:0] dimes_next;
    logic [6:0] deposit_next;

    // Clamp a 9-bit intermediate inventory value to the 8-bit counter range.
    function automatic logic [7:0] saturate(input logic [8:0] value);
        return value[8] ? 8'hFF : value[7:0];
    endfunction

    assign EMPTY     = (count_cans == 8'd0);
    assign USE_EXACT = (count_nickels == 8'd0) || (count_dimes < 8'd2);

    // Work out the accepted coin, the vend decision, the change to return and
    // the next inventory; loads are folded in before change availability is judged.
    always_comb begin
        coin_value     = 7'd0;
        if (QUARTER_IN) begin
            coin_value = 7'd25;
        end else if (DIME_IN) begin
            coin_value = 7'd10;
        end else if (NICKEL_IN) begin
            coin_value = 7'd5;
        end

        coin_accept    = (coin_value != 7'd0) && (count_cans != 8'd0);
        deposit_sum    = count_deposit + coin_value;
        vend           = coin_accept && (deposit_sum >= PRICE);
        change         = deposit_sum - PRICE;

        need_nickel    = vend && ((change == 7'd5)  || (change == 7'd15));
        need_dime      = vend && ((change == 7'd10) || (change == 7'd15));
        need_two_dimes = vend && (change == 7'd20);

        cans_sum       = {1'b0, count_cans}    + (LOAD_CANS  ? {1'b0, CANS}    : 9'd0);
        nickels_sum    = {1'b0, count_nickels} + (LOAD_COINS ? {1'b0, NICKELS} : 9'd0);
        dimes_sum      = {1'b0, count_dimes}   + (LOAD_COINS ? {1'b0, DIMES}   : 9'd0);

        give_nickel    = need_nickel    && (nickels_sum != 9'd0);
        give_dime      = need_dime      && (dimes_sum   != 9'd0);
        give_two_dimes = need_two_dimes && (dimes_sum   >= 9'd2);

        cans_raw       = cans_sum    - {8'd0, vend};
        nickels_raw    = nickels_sum - {8'd0, give_nickel};
        dimes_raw      = dimes_sum   - {8'd0, give_dime} - (give_two_dimes ? 9'd2 : 9'd0);

        cans_next      = saturate(cans_raw);
        nickels_next   = saturate(nickels_raw);
        dimes_next     = saturate(dimes_raw);

        deposit_next   = count_deposit;
        if (vend) begin
            deposit_next = 7'd0;
        end else if (coin_accept) begin
            deposit_next = deposit_sum;
        end
    end

    // Register inventory, deposit and the single-cycle vend/change pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_cans    <= 8'd0;
            count_nickels <= 8'd0;
            count_dimes   <= 8'd0;
            count_deposit <= 7'd0;
            DISPENSE      <= 1'b0;
            NICKEL_OUT    <= 1'b0;
            DIME_OUT      <= 1'b0;
            TWO_DIME_OUT  <= 1'b0;
        end else begin
            count_cans    <= cans_next;
            count_nickels <= nickels_next;
            count_dimes   <= dimes_next;
            count_deposit <= deposit_next;
            DISPENSE      <= vend;
            NICKEL_OUT    <= give_nickel;
            DIME_OUT      <= give_dime;
            TWO_DIME_OUT  <= give_two_dimes;
        end
    end

endmodule

// File: tb/tb_dkm.sv
// Self-checking bench for the dkm vending controller: directed scenarios
// followed by randomized traffic checked against a cents-and-counts model.
module tb_dkm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       LOAD_COINS = 1'b0;
    logic       LOAD_CANS = 1'b0;
    logic [7:0] NICKELS = 8'd0;
    logic [7:0] DIMES = 8'd0;
    logic [7:0] CANS = 8'd0;
    logic       NICKEL_IN = 1'b0;
    logic       DIME_IN = 1'b0;
    logic       QUARTER_IN = 1'b0;
    logic       EMPTY;
    logic       DISPENSE;
    logic       NICKEL_OUT;
    logic       DIME_OUT;
    logic       TWO_DIME_OUT;
    logic       USE_EXACT;

    int checks = 0;
    int errors = 0;

    int   m_cans, m_nickels, m_dimes, m_deposit;
    logic m_dispense, m_nickel_out, m_dime_out, m_two_dime_out;

    dkm dut (
        .CLK(CLK), .RST(RST), .LOAD_COINS(LOAD_COINS), .LOAD_CANS(LOAD_CANS),
        .NICKELS(NICKELS), .DIMES(DIMES), .CANS(CANS),
        .NICKEL_IN(NICKEL_IN), .DIME_IN(DIME_IN), .QUARTER_IN(QUARTER_IN),
        .EMPTY(EMPTY), .DISPENSE(DISPENSE), .NICKEL_OUT(NICKEL_OUT),
        .DIME_OUT(DIME_OUT), .TWO_DIME_OUT(TWO_DIME_OUT), .USE_EXACT(USE_EXACT)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    // Output bundle order: {EMPTY, DISPENSE, NICKEL_OUT, DIME_OUT, TWO_DIME_OUT, USE_EXACT}
    function automatic logic [5:0] observedBundle();
        return {EMPTY, DISPENSE, NICKEL_OUT, DIME_OUT, TWO_DIME_OUT, USE_EXACT};
    endfunction

    function automatic logic [5:0] expectedBundle();
        return {m_cans == 0, m_dispense, m_nickel_out, m_dime_out, m_two_dime_out,
                (m_nickels == 0) || (m_dimes < 2)};
    endfunction

    function automatic int clamp255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        m_cans = 0;
        m_nickels = 0;
        m_dimes = 0;
        m_deposit = 0;
        m_dispense = 1'b0;
        m_nickel_out = 1'b0;
        m_dime_out = 1'b0;
        m_two_dime_out = 1'b0;
    endtask

    // Asynchronous reset pulse, checked mid-cycle before any clock edge sees it.
    task automatic doReset(input string tag);
        @(negedge CLK);
        LOAD_COINS = 1'b0; LOAD_CANS = 1'b0;
        NICKELS = 8'd0; DIMES = 8'd0; CANS = 8'd0;
        NICKEL_IN = 1'b0; DIME_IN = 1'b0; QUARTER_IN = 1'b0;
        RST = 1'b1;
        #2;
        clearModel();
        checkOutput(tag, observedBundle(), expectedBundle());
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // One clock cycle of stimulus; coins = {quarter, dime, nickel}.
    task automatic applyStimulus(input logic lcoins, input logic lcans,
                                 input logic [7:0] n, input logic [7:0] d, input logic [7:0] c,
                                 input logic [2:0] coins, input string tag);
        int coin;
        int change;
        int vend;
        int cans_total;
        int nickels_total;
        int dimes_total;
        LOAD_COINS = lcoins; LOAD_CANS = lcans;
        NICKELS = n; DIMES = d; CANS = c;
        QUARTER_IN = coins[2]; DIME_IN = coins[1]; NICKEL_IN = coins[0];
        @(posedge CLK);
        #1;
        coin = coins[2] ? 25 : (coins[1] ? 10 : (coins[0] ? 5 : 0));
        change = -1;
        vend = 0;
        if (coin > 0 && m_cans > 0) begin
            if (m_deposit + coin >= 50) begin
                vend = 1;
                change = m_deposit + coin - 50;
                m_deposit = 0;
            end else begin
                m_deposit = m_deposit + coin;
            end
        end
        cans_total    = m_cans    + (lcans  ? int'(c) : 0);
        nickels_total = m_nickels + (lcoins ? int'(n) : 0);
        dimes_total   = m_dimes   + (lcoins ? int'(d) : 0);
        m_dispense     = (vend == 1);
        m_nickel_out   = ((change == 5)  || (change == 15)) && (nickels_total > 0);
        m_dime_out     = ((change == 10) || (change == 15)) && (dimes_total > 0);
        m_two_dime_out = (change == 20) && (dimes_total >= 2);
        m_cans    = clamp255(cans_total - vend);
        m_nickels = clamp255(nickels_total - (m_nickel_out ? 1 : 0));
        m_dimes   = clamp255(dimes_total - (m_dime_out ? 1 : 0) - (m_two_dime_out ? 2 : 0));
        checkOutput(tag, observedBundle(), expectedBundle());
    endtask

    task automatic idle(input string tag);
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b000, tag);
    endtask

    initial begin
        logic       lc, lk;
        logic [7:0] rn, rd, rc;
        logic [2:0] rcoins;

        // Exact 50, no change inventory
        doReset("t1_reset");
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd1, 3'b000, "t1_load");
        checkOutput("t1_load_empty", EMPTY, 0);
        checkOutput("t1_load_exact", USE_EXACT, 1);
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t1_q1");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t1_q2");
        checkOutput("t1_vend", observedBundle(), 6'b110001);
        idle("t1_idle");
        checkOutput("t1_after", observedBundle(), 6'b100001);

        // 55 cents: nickel change
        doReset("t2_reset");
        applyStimulus(1'b1, 1'b1, 8'd1, 8'd2, 8'd1, 3'b000, "t2_load");
        checkOutput("t2_exact_loaded", USE_EXACT, 0);
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b010, "t2_d1");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b010, "t2_d2");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b010, "t2_d3");
        checkOutput("t2_exact_before", USE_EXACT, 0);
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t2_q");
        checkOutput("t2_vend", observedBundle(), 6'b111001);
        idle("t2_idle");
        checkOutput("t2_after", observedBundle(), 6'b100001);

        // 60 cents: dime change
        doReset("t3_reset");
        applyStimulus(1'b1, 1'b1, 8'd1, 8'd2, 8'd1, 3'b000, "t3_load");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b010, "t3_d");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t3_q1");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t3_q2");
        checkOutput("t3_vend", observedBundle(), 6'b110101);

        // 65 cents: nickel plus dime
        doReset("t4_reset");
        applyStimulus(1'b1, 1'b1, 8'd2, 8'd3, 8'd1, 3'b000, "t4_load");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b001, "t4_n");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b010, "t4_d");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t4_q1");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t4_q2");
        checkOutput("t4_vend", observedBundle(), 6'b111100);
        idle("t4_idle");
        checkOutput("t4_after", observedBundle(), 6'b100000);

        // 70 cents: two dimes
        doReset("t5_reset");
        applyStimulus(1'b1, 1'b1, 8'd1, 8'd4, 8'd1, 3'b000, "t5_load");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b010, "t5_d1");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b010, "t5_d2");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t5_q1");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t5_q2");
        checkOutput("t5_vend", observedBundle(), 6'b110010);
        idle("t5_idle");
        checkOutput("t5_after", observedBundle(), 6'b100000);

        // No cans: coins ignored
        doReset("t6_reset");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t6_q1");
        applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 3'b100, "t6_q2");
        checkOutput("t6_no_vend", observedBundle(), 6'b100001);
        checkOutput("t6_deposit", dut.count_deposit, 0);

        // Saturation of can inventory
        doReset("t7_reset");
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd200, 3'b000, "t7_load1");
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd200, 3'b000, "t7_load2");
        checkOutput("t7_sat_cans", dut.count_cans, 255);

        // Randomized traffic against the model
        doReset("rnd_reset");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset("rnd_midreset");
            end
            lc = ($urandom_range(0, 11) == 0);
            lk = ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 3));
            rd = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 3));
            rc = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 2));
            rcoins = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            applyStimulus(lc, lk, rn, rd, rc, rcoins, "rnd_cycle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dkm.md
Name: dkm

Overview:
- Drink-vending machine controller; each can costs 50 cents.
- Accepts nickel (5), dime (10) and quarter (25) pulses and keeps an inventory of cans, nickels and dimes.
- Dispenses a can and returns change once the deposit reaches 50 cents.
- Top-level vending block; inventory is loaded by the service interface.

Parameters:
- None. Price is fixed at 50 cents; coin values are fixed at 5/10/25.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- LOAD_COINS  input  1  add NICKELS and DIMES to coin inventory this cycle
- LOAD_CANS  input  1  add CANS to can inventory this cycle
- NICKELS  input  8  nickels to add on LOAD_COINS
- DIMES  input  8  dimes to add on LOAD_COINS
- CANS  input  8  cans to add on LOAD_CANS
- NICKEL_IN  input  1  one-cycle pulse: 5 cents inserted
- DIME_IN  input  1  one-cycle pulse: 10 cents inserted
- QUARTER_IN  input  1  one-cycle pulse: 25 cents inserted
- EMPTY  output  1  can inventory is zero
- DISPENSE  output  1  one-cycle pulse: can dispensed
- NICKEL_OUT  output  1  one-cycle pulse with DISPENSE: return one nickel
- DIME_OUT  output  1  one-cycle pulse with DISPENSE: return one dime
- TWO_DIME_OUT  output  1  one-cycle pulse with DISPENSE: return two dimes
- USE_EXACT  output  1  change inventory insufficient; customer should use exact change

Behaviour:
- Ports are instantiated positionally, in the order listed above.
- Internal registers:
  - count_cans, count_nickels, count_dimes: 8-bit each
  - count_deposit: cents, at least 7 bits
- Reset (RST=1, asynchronous):
  - all counters cleared
  - DISPENSE, NICKEL_OUT, DIME_OUT, TWO_DIME_OUT = 0
  - therefore EMPTY=1 and USE_EXACT=1
- EMPTY = (count_cans==0), combinational from the register.
- USE_EXACT = (count_nickels==0) || (count_dimes<2), combinational from the registers.
- Loading:
  - On a rising edge with LOAD_CANS=1, count_cans += CANS.
  - On a rising edge with LOAD_COINS=1, count_nickels += NICKELS and count_dimes += DIMES.
  - Additions saturate at 255.
  - Loads may coincide with coin insertion; both take effect in the same edge.
- Coin acceptance:
  - Sampled on the rising edge.
  - If several coin inputs are high in one cycle, only the highest value is accepted (quarter > dime > nickel).
  - Coins inserted while count_cans==0 are ignored (not added to the deposit).
  - Deposited coins never enter the change inventory.
- Vend, decided at the edge that accepts a coin:
  - new = count_deposit + coin. If new < 50, count_deposit <= new and all pulse outputs stay 0.
  - If new >= 50, on that same edge:
    - DISPENSE <= 1
    - count_cans decrements
    - count_deposit <= 0
    - change = new - 50, which is in {0, 5, 10, 15, 20}
  - Change encoding:
    - 0: no change outputs
    - 5: NICKEL_OUT
    - 10: DIME_OUT
    - 15: NICKEL_OUT + DIME_OUT
    - 20: TWO_DIME_OUT only (DIME_OUT=0)
  - Each change coin returned decrements its counter.
  - If a needed coin is unavailable, its output is not asserted and its counter does not go below 0. The vend still completes.
- Output timing:
  - Outputs are valid right after the accepting edge; EMPTY and USE_EXACT reflect the post-vend counts in that same cycle.
  - DISPENSE and the change outputs are cleared on the next edge (single-cycle pulses).
- Latency: a coin pulse sampled at edge N produces DISPENSE and change outputs during cycle N..N+1.
- Reset mid-transaction discards the deposit and all inventory.

Test Plan:
- Reset; load 1 can; insert q, q -> after load EMPTY=0, USE_EXACT=1; after second quarter EMPTY=1, DISPENSE=1, no change, USE_EXACT=1.
- Reset; 1 can; coins (1,2); insert d, d, d, q (55) -> USE_EXACT=0 until the vend, then DISPENSE=1, NICKEL_OUT=1, EMPTY=1, USE_EXACT=1.
- Reset; 1 can; coins (1,2); insert d, q, q (60) -> DISPENSE=1, DIME_OUT=1, EMPTY=1, USE_EXACT=1.
- Reset; 1 can; coins (2,3); insert n, d, q, q (65) -> DISPENSE=1, NICKEL_OUT=1, DIME_OUT=1, EMPTY=1, USE_EXACT=0.
- Reset; 1 can; coins (1,4); insert d, d, q, q (70) -> DISPENSE=1, TWO_DIME_OUT=1, DIME_OUT=0, EMPTY=1, USE_EXACT=0.
- Reset with cans=0; insert q, q -> no DISPENSE, deposit remains 0; one cycle after any DISPENSE all pulse outputs return to 0.
